// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio
// Purpose  : Word-addressed data memory with a small memory-mapped I/O window
//            at the top of the address space: synchronized button levels,
//            sticky read-to-clear button edges, a free-running timer and a
//            software-written output register. Reads are registered (1 cycle).
// Options  : define DMEM_MMIO_TIMER_EN to build the prescaler, TIMER and tick;
//            without it TIMER reads 0, ignores writes and tick is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_mmio #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int RAM_DEPTH  = 4092,
    parameter int NUM_BTN    = 4,
    parameter int TIMER_DIV  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wEn,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    input  logic [NUM_BTN-1:0]    btn,
    output logic [DATA_WIDTH-1:0] outReg,
    output logic                  tick
);

    // MMIO window occupies the last four word addresses
    localparam int                    c_mmio_base = (2 ** ADDR_WIDTH) - 4;
    localparam logic [ADDR_WIDTH-1:0] c_addr_lvl  = ADDR_WIDTH'(c_mmio_base);
    localparam logic [ADDR_WIDTH-1:0] c_addr_edge = ADDR_WIDTH'(c_mmio_base + 1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_tmr  = ADDR_WIDTH'(c_mmio_base + 2);
    localparam logic [ADDR_WIDTH-1:0] c_addr_out  = ADDR_WIDTH'(c_mmio_base + 3);
    localparam logic [ADDR_WIDTH-1:0] c_ram_top   = ADDR_WIDTH'(RAM_DEPTH);
    localparam int                    c_ram_aw    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    // Reject configurations that would overlap RAM with MMIO or break the counters
    generate
        if (RAM_DEPTH > c_mmio_base || RAM_DEPTH < 1 || NUM_BTN < 1 ||
            NUM_BTN > DATA_WIDTH || TIMER_DIV < 1) begin : g_bad_cfg
            $error("dmem_mmio: illegal parameter combination");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [c_ram_aw-1:0]   w_ram_idx;
    logic                  w_in_ram;
    logic                  w_rd_edge;
    logic                  w_wr_out;
    logic [NUM_BTN-1:0]    r_sync1;
    logic [NUM_BTN-1:0]    r_sync2;
    logic [NUM_BTN-1:0]    r_sync3;
    logic [NUM_BTN-1:0]    w_rise;
    logic [NUM_BTN-1:0]    w_edge_clr;
    logic [NUM_BTN-1:0]    r_edge;
    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] w_timer_rd;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_ram_idx = addr[c_ram_aw-1:0];
    assign w_in_ram  = (addr < c_ram_top);
    assign w_rd_edge = !wEn && (addr == c_addr_edge);
    assign w_wr_out  = wEn && (addr == c_addr_out);

    // RAM write port; deliberately unreset so contents survive a reset pulse
    always_ff @(posedge clock) begin
        if (wEn && w_in_ram) begin
            r_mem[w_ram_idx] <= dataIn;
        end
    end

    // Two-flop synchronizer plus one history stage for rising-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // A read clears only the bits it returned, so a rise in that cycle survives
    assign w_rise     = r_sync2 & ~r_sync3;
    assign w_edge_clr = w_rd_edge ? r_edge : '0;

    // Sticky edge flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_edge_clr) | w_rise;
        end
    end

    // Software-written output register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out <= '0;
        end else if (w_wr_out) begin
            r_out <= dataIn;
        end
    end

    assign outReg = r_out;

`ifdef DMEM_MMIO_TIMER_EN
    localparam int              c_pw         = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [c_pw-1:0] c_presc_last = c_pw'(TIMER_DIV - 1);

    logic [c_pw-1:0]       r_presc;
    logic [DATA_WIDTH-1:0] r_timer;
    logic                  r_tick;
    logic                  w_wr_tmr;

    assign w_wr_tmr = wEn && (addr == c_addr_tmr);

    // Prescaled timer; a software load wins over a same-cycle increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_timer <= '0;
            r_tick  <= 1'b0;
        end else if (w_wr_tmr) begin
            r_presc <= '0;
            r_timer <= dataIn;
            r_tick  <= 1'b0;
        end else if (r_presc == c_presc_last) begin
            r_presc <= '0;
            r_timer <= r_timer + 1'b1;
            r_tick  <= 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
            r_tick  <= 1'b0;
        end
    end

    assign w_timer_rd = r_timer;
    assign tick       = r_tick;
`else
    assign w_timer_rd = '0;
    assign tick       = 1'b0;
`endif

    // Read decode: RAM below the MMIO window, registers inside it, zero elsewhere
    always_comb begin
        w_rdata = '0;
        if (w_in_ram) begin
            w_rdata = r_mem[w_ram_idx];
        end else begin
            case (addr)
                c_addr_lvl:  w_rdata = DATA_WIDTH'(r_sync2);
                c_addr_edge: w_rdata = DATA_WIDTH'(r_edge);
                c_addr_tmr:  w_rdata = w_timer_rd;
                c_addr_out:  w_rdata = r_out;
                default:     w_rdata = '0;
            endcase
        end
    end

    // Registered read port, refreshed every cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dataOut <= '0;
        end else begin
            dataOut <= w_rdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of the data word, the output register and the timer.
REQ-002 Parameter ADDR_WIDTH, default 12, sets the width of the word address.
REQ-003 Parameter RAM_DEPTH, default 4092, sets the RAM word count; it SHALL be at most MMIO_BASE, where MMIO_BASE = 2^ADDR_WIDTH - 4.
REQ-004 Parameter NUM_BTN, default 4, sets the number of button inputs (1..DATA_WIDTH).
REQ-005 Parameter TIMER_DIV, default 1, sets the clock cycles per timer increment (>=1).
REQ-006 clock  in  1  sole clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 wEn  in  1  write enable for addr.
REQ-009 addr  in  ADDR_WIDTH  word address.
REQ-010 dataIn  in  DATA_WIDTH  write data.
REQ-011 dataOut  out  DATA_WIDTH  registered read data.
REQ-012 btn  in  NUM_BTN  asynchronous button levels.
REQ-013 outReg  out  DATA_WIDTH  software-written output register (score/LED drive).
REQ-014 tick  out  1  one-cycle pulse on each timer increment.

Function
REQ-015 Address map: 0..RAM_DEPTH-1 RAM; MMIO_BASE+0 BTN_LEVEL (RO); +1 BTN_EDGE (read-clear); +2 TIMER (RW); +3 OUT (RW); any other address reads 0 and ignores writes.
REQ-016 Read latency SHALL be exactly 1 cycle: dataOut at edge N+1 reflects addr presented at edge N; dataOut holds its value between reads and is updated every cycle.
REQ-017 A RAM write SHALL occur on the rising edge when wEn=1; a read of the same address in the same cycle SHALL return the old data (read-before-write).
REQ-018 btn SHALL pass through a 2-flop synchronizer; BTN_LEVEL returns the synchronized levels zero-extended to DATA_WIDTH.
REQ-019 A synchronized 0->1 transition on bit i SHALL set sticky bit i of BTN_EDGE.
REQ-020 A read of BTN_EDGE (wEn=0) SHALL return the current value and then clear the bits it returned; an edge arriving in the clearing cycle SHALL remain set.
REQ-021 Writes to BTN_LEVEL and BTN_EDGE SHALL be ignored.
REQ-022 The prescaler SHALL count 0..TIMER_DIV-1; on its terminal count it SHALL wrap to 0, TIMER SHALL increment by 1 (wrapping from 2^DATA_WIDTH-1 to 0), and tick SHALL be 1 for that cycle.
REQ-023 A write to TIMER SHALL load dataIn and zero the prescaler; a write takes priority over a same-cycle increment, and tick SHALL be 0 in that cycle.
REQ-024 A write to OUT SHALL load dataIn into outReg on the same edge; a read of OUT returns outReg.
REQ-025 RAM contents are undefined at power-up and SHALL NOT be cleared by reset.

Reset
REQ-026 While reset=1: dataOut=0, outReg=0, tick=0, TIMER=0, prescaler=0, BTN_EDGE=0, and synchronizer flops=0, all applied immediately without waiting for a clock edge.
REQ-027 On reset deassertion, the first synchronized button high SHALL register as an edge; a write in progress when reset asserts SHALL be dropped for all MMIO registers.

Configuration
REQ-028 The macro DMEM_MMIO_TIMER_EN, when defined, SHALL compile in the prescaler, TIMER and tick as specified above.
REQ-029 Without DMEM_MMIO_TIMER_EN: TIMER reads 0, writes to TIMER are ignored, tick is tied to 0, and no timer flops exist.

Verification
REQ-030 Write 0xDEADBEEF to addr 5, then read addr 5 -> dataOut=0xDEADBEEF one cycle after the read address is presented; a read of addr 4092 with btn=0 -> 0.
REQ-031 Raise btn=4'b0010, wait 3 cycles, read 4093 -> 0x2; read again -> 0x0; raise btn[0] on the clear cycle -> the next read returns 0x1.
REQ-032 With TIMER_DIV=4 and the macro defined: after reset, 12 cycles -> TIMER=3, with tick pulsed 3 times, each pulse 1 cycle wide.
REQ-033 Write 0xFFFFFFFF to 4094 with TIMER_DIV=1 -> TIMER reads 0 on the next increment and tick=1 on that increment.
REQ-034 Write 0x1234 to 4095, then assert reset asynchronously mid-cycle -> outReg=0 and dataOut=0 before the next edge, while RAM addr 5 still reads 0xDEADBEEF after reset releases.
REQ-035 Build without the macro, write 7 to 4094 -> a read returns 0 and tick stays 0 for 100 cycles.
